// File: rtl/wm_extract.sv
// rtl/wm_extract.sv - watermark extractor: 4x4 block LSB-majority vote repacked into 128-bit words
module wm_extract #(
    parameter int BAND_WIDTH    = 512,
    parameter int WM_BAND_WIDTH = 128,
    parameter int BLK_WIDTH     = 4,
    parameter int IM_DATA_WIDTH = 8,
    parameter int IM_CHN_CNT    = 4,
    parameter int IM_WIDTH      = 800
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [BAND_WIDTH-1:0]    S_axis_im_tdata,
    input  logic                     S_axis_im_tvalid,
    output logic                     S_axis_im_tready,
    input  logic                     S_axis_im_tlast,
    output logic [WM_BAND_WIDTH-1:0] M_axis_wm_tdata,
    output logic                     M_axis_wm_tvalid,
    input  logic                     M_axis_wm_tready,
    output logic                     M_axis_wm_tlast,
    output logic                     o_done,
    output logic                     o_err
);
    localparam int PIX_W         = IM_DATA_WIDTH * IM_CHN_CNT;
    localparam int PIX_PER_BEAT  = BAND_WIDTH / PIX_W;
    localparam int BLK_PER_BEAT  = PIX_PER_BEAT / BLK_WIDTH;
    localparam int BEATS_PER_ROW = IM_WIDTH / PIX_PER_BEAT;
    localparam int BLK_PER_ROW   = IM_WIDTH / BLK_WIDTH;
    localparam int TOTAL_BITS    = BLK_PER_ROW * BLK_PER_ROW;
    localparam int N_WORDS       = (TOTAL_BITS + WM_BAND_WIDTH - 1) / WM_BAND_WIDTH;
    localparam int VOTE_CHN      = 3;
    localparam int VOTE_THR      = VOTE_CHN * BLK_WIDTH * BLK_WIDTH / 2;
    localparam int CW            = $clog2(VOTE_CHN * BLK_WIDTH + 1);
    localparam int AW            = $clog2(VOTE_CHN * BLK_WIDTH * BLK_WIDTH + 1);
    localparam int COL_W         = $clog2(BEATS_PER_ROW);
    localparam int ROW_W         = $clog2(IM_WIDTH);
    localparam int BIT_W         = $clog2(TOTAL_BITS + 1);
    localparam int WORD_W        = $clog2(N_WORDS);
    localparam int POS_W         = $clog2(WM_BAND_WIDTH);

    logic [COL_W-1:0]         col_beat;
    logic [ROW_W-1:0]         row;
    logic [BIT_W-1:0]         bit_cnt;
    logic [WORD_W-1:0]        word_idx;
    logic [WM_BAND_WIDTH-1:0] pack;
    logic [WM_BAND_WIDTH-1:0] pack_next;
    logic [AW-1:0]            acc [BEATS_PER_ROW][BLK_PER_BEAT];
    logic [CW-1:0]            contrib [BLK_PER_BEAT];
    logic [AW-1:0]            acc_sum [BLK_PER_BEAT];
    logic [BLK_PER_BEAT-1:0]  vote_bits;
    logic [1:0]               phase;
    logic [POS_W-1:0]         bit_pos;
    logic                     accept;
    logic                     last_col;
    logic                     last_beat;
    logic                     word_completes;
    logic                     early_err;
    logic                     miss_err;
    logic                     load_word;
    logic                     unused_chn;

    // Channel 3 and the upper channel bits never vote; fold them into a sink.
    assign unused_chn = ^S_axis_im_tdata;

    assign phase     = row[1:0];
    assign bit_pos   = bit_cnt[POS_W-1:0];
    assign last_col  = (col_beat == COL_W'(BEATS_PER_ROW - 1));
    assign last_beat = last_col && (row == ROW_W'(IM_WIDTH - 1));
    assign accept    = S_axis_im_tvalid && S_axis_im_tready;

    // Counter-only so that tready never depends on tvalid.
    assign word_completes = (phase == 2'd3) &&
                            ((bit_pos == POS_W'(WM_BAND_WIDTH - BLK_PER_BEAT)) ||
                             (bit_cnt == BIT_W'(TOTAL_BITS - BLK_PER_BEAT)));

    assign S_axis_im_tready = !(M_axis_wm_tvalid && !M_axis_wm_tready && word_completes);

    assign early_err = accept && S_axis_im_tlast && !last_beat;
    assign miss_err  = accept && last_beat && !S_axis_im_tlast;
    assign load_word = accept && !early_err && word_completes;

    always_comb begin
        for (int j = 0; j < BLK_PER_BEAT; j++) begin
            contrib[j] = '0;
            for (int p = 0; p < BLK_WIDTH; p++) begin
                for (int c = 0; c < VOTE_CHN; c++) begin
                    contrib[j] = contrib[j] +
                        CW'(S_axis_im_tdata[(j * BLK_WIDTH + p) * PIX_W + c * IM_DATA_WIDTH]);
                end
            end
            acc_sum[j]   = acc[col_beat][j] + AW'(contrib[j]);
            vote_bits[j] = (acc_sum[j] >= AW'(VOTE_THR));
        end
    end

    always_comb begin
        pack_next = pack;
        pack_next[bit_pos +: BLK_PER_BEAT] = vote_bits;
    end

    // Phase 0 overwrites, so the accumulator needs neither reset nor a clear pass.
    always_ff @(posedge clk) begin
        if (accept && !early_err && phase != 2'd3) begin
            for (int j = 0; j < BLK_PER_BEAT; j++) begin
                acc[col_beat][j] <= (phase == 2'd0) ? AW'(contrib[j]) : acc_sum[j];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_beat <= '0;
            row      <= '0;
            bit_cnt  <= '0;
            word_idx <= '0;
            pack     <= '0;
        end else if (accept) begin
            if (early_err || last_beat) begin
                col_beat <= '0;
                row      <= '0;
                bit_cnt  <= '0;
                word_idx <= '0;
                pack     <= '0;
            end else begin
                if (last_col) begin
                    col_beat <= '0;
                    row      <= row + 1'b1;
                end else begin
                    col_beat <= col_beat + 1'b1;
                end
                if (phase == 2'd3) begin
                    bit_cnt <= bit_cnt + BIT_W'(BLK_PER_BEAT);
                    if (word_completes) begin
                        pack     <= '0;
                        word_idx <= word_idx + 1'b1;
                    end else begin
                        pack <= pack_next;
                    end
                end
            end
        end
    end

    // A fresh load takes priority over the drain so the register refills without a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            M_axis_wm_tdata  <= '0;
            M_axis_wm_tvalid <= 1'b0;
            M_axis_wm_tlast  <= 1'b0;
            o_done           <= 1'b0;
            o_err            <= 1'b0;
        end else begin
            o_done <= M_axis_wm_tvalid && M_axis_wm_tready && M_axis_wm_tlast;
            o_err  <= early_err || miss_err;
            if (load_word) begin
                M_axis_wm_tdata  <= pack_next;
                M_axis_wm_tvalid <= 1'b1;
                M_axis_wm_tlast  <= (word_idx == WORD_W'(N_WORDS - 1));
            end else if (M_axis_wm_tready) begin
                M_axis_wm_tvalid <= 1'b0;
                M_axis_wm_tlast  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_wm_extract.sv
// tb/tb_wm_extract.sv - directed self-checking bench for wm_extract
module tb_wm_extract;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [511:0] s_tdata = '0;
    logic         s_tvalid = 1'b0;
    logic         s_tready;
    logic         s_tlast = 1'b0;
    logic [127:0] m_tdata;
    logic         m_tvalid;
    logic         m_tready = 1'b1;
    logic         m_tlast;
    logic         o_done;
    logic         o_err;

    int n_vec = 0;
    int n_err = 0;
    logic [127:0] got_d[$];
    bit           got_l[$];
    int done_cnt = 0;
    int err_cnt = 0;
    int stall_cnt = 0;

    wm_extract dut (
        .clk              (clk),
        .rst              (rst),
        .S_axis_im_tdata  (s_tdata),
        .S_axis_im_tvalid (s_tvalid),
        .S_axis_im_tready (s_tready),
        .S_axis_im_tlast  (s_tlast),
        .M_axis_wm_tdata  (m_tdata),
        .M_axis_wm_tvalid (m_tvalid),
        .M_axis_wm_tready (m_tready),
        .M_axis_wm_tlast  (m_tlast),
        .o_done           (o_done),
        .o_err            (o_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (m_tvalid && m_tready) begin
            got_d.push_back(m_tdata);
            got_l.push_back(m_tlast);
        end
        if (o_done) done_cnt++;
        if (o_err) err_cnt++;
        if (s_tvalid && !s_tready) stall_cnt++;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        got_d.delete();
        got_l.delete();
        done_cnt  = 0;
        err_cnt   = 0;
        stall_cnt = 0;
    endtask

    task automatic send(input logic [511:0] d, input logic l);
        int guard = 0;
        s_tdata  = d;
        s_tvalid = 1'b1;
        s_tlast  = l;
        @(negedge clk);
        while (!s_tready && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 1000) begin
            n_vec++;
            n_err++;
            $error("FAIL send_timeout: tready stuck low for %0d cycles", guard);
        end
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    // Col 0 only: block0 24 LSBs, block1 23 (+ ignored ch3), block2 48, block3 upper bits only.
    function automatic logic [511:0] thr_beat(input int r, input int c);
        logic [511:0] d = '0;
        if (c == 0) begin
            for (int ch = 0; ch < 3; ch++) begin
                d[0 * 32 + ch * 8] = 1'b1;
                d[1 * 32 + ch * 8] = 1'b1;
                d[4 * 32 + ch * 8] = 1'b1;
                if ((r % 4) != 3 || ch != 2) d[5 * 32 + ch * 8] = 1'b1;
                for (int p = 8; p < 12; p++) d[p * 32 + ch * 8] = 1'b1;
            end
            d[6 * 32 + 24] = 1'b1;
            for (int p = 12; p < 16; p++) d[p * 32 +: 32] = 32'hFEFE_FEFE;
        end
        return d;
    endfunction

    function automatic logic [511:0] band_beat(input int r);
        return (((r / 4) % 2) == 0) ? {512{1'b1}} : '0;
    endfunction

    logic [127:0] ones128;
    logic [127:0] exp_bp [4];
    logic [127:0] exp_w;

    initial begin
        ones128   = '1;
        exp_bp[0] = ones128;
        exp_bp[1] = (128'd1 << 72) - 128'd1;
        exp_bp[2] = '0;
        exp_bp[3] = ~((128'd1 << 16) - 128'd1);

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_tvalid", 128'(m_tvalid), 128'd0);
        check("rst_tlast", 128'(m_tlast), 128'd0);
        check("rst_tdata", m_tdata, 128'd0);
        check("rst_done", 128'(o_done), 128'd0);
        check("rst_err", 128'(o_err), 128'd0);
        check("rst_tready", 128'(s_tready), 128'd1);

        // Threshold blocks; word 0 is held in the output register, then reset mid-frame.
        clear_mon();
        m_tready = 1'b0;
        for (int b = 0; b < 200; b++) send(thr_beat(b / 50, b % 50), 1'b0);
        check("thr_tvalid", 128'(m_tvalid), 128'd1);
        check("thr_word0", m_tdata, 128'h5);
        check("thr_tlast", 128'(m_tlast), 128'd0);
        rst = 1'b1;
        #1;
        check("arst_tvalid", 128'(m_tvalid), 128'd0);
        check("arst_tdata", m_tdata, 128'd0);
        check("arst_tready", 128'(s_tready), 128'd1);
        @(posedge clk);
        #1 rst = 1'b0;

        // Backpressure: sink stalled from start until 200 cycles after word 0 appears.
        clear_mon();
        m_tready = 1'b0;
        fork
            for (int b = 0; b < 600; b++) send(band_beat(b / 50), 1'b0);
            begin
                int k = 0;
                while (!m_tvalid && k < 2000) begin
                    @(posedge clk);
                    k++;
                end
                repeat (200) @(posedge clk);
                #1 m_tready = 1'b1;
            end
        join
        repeat (3) @(posedge clk);
        #1;
        check("bp_stalled", 128'(stall_cnt > 0), 128'd1);
        check("bp_count", 128'(got_d.size()), 128'd4);
        for (int i = 0; i < 4 && i < got_d.size(); i++) begin
            check($sformatf("bp_word%0d", i), got_d[i], exp_bp[i]);
        end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;

        // Early tlast on beat 1000 with word 6 still held in the output register.
        clear_mon();
        m_tready = 1'b1;
        for (int b = 0; b < 960; b++) send('1, 1'b0);
        m_tready = 1'b0;
        for (int b = 960; b < 999; b++) send('1, 1'b0);
        send('1, 1'b1);
        check("early_err_pulse", 128'(o_err), 128'd1);
        check("early_held_valid", 128'(m_tvalid), 128'd1);
        check("early_held_tlast", 128'(m_tlast), 128'd0);
        m_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("early_err_low", 128'(o_err), 128'd0);
        check("early_err_cnt", 128'(err_cnt), 128'd1);
        check("early_count", 128'(got_d.size()), 128'd7);
        for (int i = 0; i < got_d.size(); i++) begin
            check($sformatf("early_word%0d", i), got_d[i], ones128);
            check($sformatf("early_tlast%0d", i), 128'(got_l[i]), 128'd0);
        end

        // Clean all-0xFF frame immediately after the aborted one.
        clear_mon();
        for (int b = 0; b < 40000; b++) send('1, b == 39999);
        repeat (4) @(posedge clk);
        #1;
        check("ff_count", 128'(got_d.size()), 128'd313);
        check("ff_done_cnt", 128'(done_cnt), 128'd1);
        check("ff_err_cnt", 128'(err_cnt), 128'd0);
        for (int i = 0; i < got_d.size(); i++) begin
            exp_w = (i == 312) ? {64'h0, {64{1'b1}}} : ones128;
            check($sformatf("ff_word%0d", i), got_d[i], exp_w);
            check($sformatf("ff_tlast%0d", i), 128'(got_l[i]), 128'(i == 312));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/wm_extract.md
# wm_extract

Watermark extractor for the 800×800 RGBA image pipeline. It consumes a watermarked image as a row-major AXI-stream of 512-bit beats, with 16 pixels per beat and 50 beats per row. It recovers one watermark bit per 4×4 pixel block by an LSB-majority vote and repacks the 40000 bits into 313 128-bit words on an AXI-stream output. It sits at the far end of the embed path and returns the watermark in the same 128-bit word format the embedder's watermark input accepts.

## Interface
- BAND_WIDTH, 512, image beat width in bits
- WM_BAND_WIDTH, 128, watermark word width in bits
- BLK_WIDTH, 4, block edge in pixels
- IM_DATA_WIDTH, 8, bits per channel
- IM_CHN_CNT, 4, channels per pixel; channel 3 is ignored
- IM_WIDTH, 800, image width and height in pixels
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- S_axis_im_tdata  in  512  16 pixels; pixel p at [p*32 +: 32], channel c at [p*32+c*8 +: 8]
- S_axis_im_tvalid  in  1  image beat valid
- S_axis_im_tready  out  1  image beat ready
- S_axis_im_tlast  in  1  marks beat 40000 of the frame
- M_axis_wm_tdata  out  128  watermark word; bit i holds watermark bit word_idx*128+i
- M_axis_wm_tvalid  out  1  word valid
- M_axis_wm_tready  in  1  word ready
- M_axis_wm_tlast  out  1  high on word 312, the final word
- o_done  out  1  one-cycle pulse when the final word is accepted
- o_err  out  1  one-cycle pulse on a framing error

## Operation
- Beat acceptance: a beat is accepted when S_axis_im_tvalid && S_axis_im_tready.
- Position counters, advanced per accepted beat:
  - col_beat: 0..49
  - row: 0..799
  - blk_row_phase = row[1:0]
- Block mapping: beat col_beat covers blocks 4*col_beat .. 4*col_beat+3.
- Per-block row contribution, for block j = 0..3 within the beat: sum of the LSBs of channels 0..2 over pixels 4j..4j+3. Range 0..12, 4 bits.
- Accumulator: register array acc[50] with 4 fields × 6 bits each. Read-modify-write happens in the accept cycle.
  - phase 0: overwrite the fields with the contributions. No clear pass is needed.
  - phase 1 or 2: add the contributions to the stored fields.
  - phase 3: total = acc + contribution, range 0..48; bit = (total >= 24). Emit 4 bits; acc is not written.
- Block numbering: block b = (row/4)*200 + 4*col_beat + j.
- Packer: a 128-bit pack register plus bit counter bit_cnt (0..40000). The 4 bits land at positions bit_cnt%128 .. +3, with j=0 lowest.
- Word completion: a word completes when bit_cnt%128 wraps, or when bit_cnt reaches 40000. The final word carries 64 valid bits with the upper 64 bits zero.
- Completed word: moves into the output register, sets M_axis_wm_tvalid, and sets tlast when word index = 312. The pack register clears.
- Flow control: S_axis_im_tready = !(M_axis_wm_tvalid && !M_axis_wm_tready && word_completes_on_this_beat). word_completes depends only on counters, never on tvalid.
- Frame end: after beat 40000 all counters return to 0 and the next frame starts immediately.
- Framing error, early: tlast on a beat other than 40000 raises o_err. All counters and the pack register reset. No tlast word is produced for the aborted frame. A word already in the output register is still delivered.
- Framing error, missing tlast: beat 40000 without tlast raises o_err, but the frame completes normally.

## Timing
- Reset values:
  - M_axis_wm_tvalid=0, M_axis_wm_tlast=0, M_axis_wm_tdata=0
  - o_done=0, o_err=0
  - all counters 0
  - S_axis_im_tready=1 once the output register is empty
- Latency: the word-completing beat is accepted in cycle t; M_axis_wm_tvalid=1 from cycle t+1. tdata and tlast hold stable until tready.
- Back-to-back operation: an output transfer and a new word completion in the same cycle are both honoured. The output register reloads without a bubble.
- Output rate: word completions occur at most once every 32 accepted beats, so a single output register suffices.
- o_done asserts the cycle after the transfer of the tlast word. o_err asserts the cycle after the offending beat.
- Reset mid-frame: all state is discarded. The next beat after reset release is treated as row 0, col 0.

## Test plan
- All-zero frame (40000 beats, tlast on beat 40000) -> 313 words, all 0; tlast only on word 312; o_done one pulse.
- All-0xFF frame -> words 0..311 = all ones; word 312 = 0x0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF.
- Threshold frame: block 0 has exactly 24 LSBs set, block 1 has 23, block 2 has 48, all others 0 -> word 0 = 0x...0005.
- Backpressure: M_axis_wm_tready low for 200 cycles from word 0 -> S_axis_im_tready drops on the beat that completes word 1; after release, words 0..312 are intact and in order.
- Early tlast on beat 1000 -> o_err pulse; any already-completed word is still delivered; the following clean all-0xFF frame produces the correct 313 words.
- rst pulsed at beat 20000 -> outputs return to reset values immediately; the next full frame extracts correctly.
